// File: rtl/reg_file_bypass.sv
// reg_file_bypass
//   Register file for the decode stage: one write port, two combinational
//   read ports, optional write-to-read bypass, optional hardwired-zero R0,
//   and a sequencer that zeroes every register after reset.
//
//   Ports
//     clk       rising-edge clock
//     reset     synchronous, active-high reset
//     RF_WRITE  write enable
//     Rdst      write address
//     RY        write data
//     Rsrc1     read address, port A
//     Rsrc2     read address, port B
//     RA        read data, port A (combinational)
//     RB        read data, port B (combinational)
//     busy      high while the clear sequence runs; writes dropped, reads 0
//
//   State table
//     state | meaning
//     CLEAR | zeroing registers one per edge (or waiting one edge when
//           | CLEAR_ON_RESET=0); busy=1
//     RUN   | normal read/write operation
module reg_file_bypass #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 5,
  parameter int ZERO_R0        = 1,
  parameter int BYPASS         = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RF_WRITE,
  input  logic [ADDR_W-1:0] Rdst,
  input  logic [DATA_W-1:0] RY,
  input  logic [ADDR_W-1:0] Rsrc1,
  input  logic [ADDR_W-1:0] Rsrc2,
  output logic [DATA_W-1:0] RA,
  output logic [DATA_W-1:0] RB,
  output logic              busy
);

  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_idx;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              clr_wr;
  logic              run_wr;
  logic              mem_we;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  // busy is a pure decode of the state register, so it rises in the cycle
  // after any reset edge regardless of the previous state.
  assign busy = (state == CLEAR);

  always_comb begin
    clr_wr  = (CLEAR_ON_RESET != 0) && busy && !reset;
    // Rdst only matters once RF_WRITE qualifies the write; an X enable
    // leaves mem_we unknown and the guarded write below is not taken.
    run_wr  = !busy && !reset && RF_WRITE &&
              !((ZERO_R0 != 0) && (Rdst == '0));
    mem_we  = clr_wr || run_wr;
    wr_addr = clr_wr ? clr_idx : Rdst;
    wr_data = clr_wr ? '0 : RY;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else if (state == CLEAR) begin
      if (CLEAR_ON_RESET == 0) begin
        state <= RUN;
      end else begin
        clr_idx <= clr_idx + ADDR_W'(1);
        if (clr_idx == {ADDR_W{1'b1}}) begin
          state <= RUN;
        end
      end
    end
  end

  // Array kept out of the reset branch: clearing is done by the sequencer.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] val;
    if (busy) begin
      val = '0;
    end else if ((ZERO_R0 != 0) && (addr == '0)) begin
      val = '0;
    end else if ((BYPASS != 0) && RF_WRITE && (Rdst == addr)) begin
      val = RY;
    end else begin
      val = mem[addr];
    end
    return val;
  endfunction

  always_comb begin
    RA = read_port(Rsrc1);
    RB = read_port(Rsrc2);
  end

endmodule

// File: tb/tb_reg_file_bypass.sv
module tb_reg_file_bypass;

  localparam int DEPTH = 32;

  logic        clk;
  logic        reset;
  logic        RF_WRITE;
  logic [4:0]  Rdst;
  logic [31:0] RY;
  logic [4:0]  Rsrc1;
  logic [4:0]  Rsrc2;
  logic [31:0] ra_b, rb_b, ra_n, rb_n;
  logic        busy_b, busy_n;

  reg_file_bypass #(.BYPASS(1)) u_byp (
    .clk(clk), .reset(reset), .RF_WRITE(RF_WRITE), .Rdst(Rdst), .RY(RY),
    .Rsrc1(Rsrc1), .Rsrc2(Rsrc2), .RA(ra_b), .RB(rb_b), .busy(busy_b)
  );

  reg_file_bypass #(.BYPASS(0)) u_nobyp (
    .clk(clk), .reset(reset), .RF_WRITE(RF_WRITE), .Rdst(Rdst), .RY(RY),
    .Rsrc1(Rsrc1), .Rsrc2(Rsrc2), .RA(ra_n), .RB(rb_n), .busy(busy_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        busy;
    logic [31:0] ra_b;
    logic [31:0] rb_b;
    logic [31:0] ra_n;
    logic [31:0] rb_n;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  // Reference model: registers as a plain array, the clear sequence reduced
  // to "edges still busy"; partial clearing is invisible because reads are 0.
  logic [31:0] m_mem [DEPTH];
  int          m_left = 0;

  // Inputs that were applied across the upcoming edge.
  bit          p_reset = 1'b1;
  bit          p_we    = 1'b0;
  logic [4:0]  p_dst   = '0;
  logic [31:0] p_ry    = '0;

  task automatic model_edge();
    if (p_reset) begin
      m_left = DEPTH;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      end
    end else if (p_we && p_dst != 0) begin
      m_mem[p_dst] = p_ry;
    end
  endtask

  function automatic logic [31:0] exp_read(input bit byp, input logic [4:0] addr);
    if (m_left > 0)                          return '0;
    if (addr == 0)                           return '0;
    if (byp && p_we && p_dst == addr)        return p_ry;
    return m_mem[addr];
  endfunction

  task automatic step(input bit rst, input bit we, input logic [4:0] dst,
                      input logic [31:0] ry, input logic [4:0] s1, input logic [4:0] s2);
    exp_t e;
    @(posedge clk);
    model_edge();
    #1;
    reset = rst; RF_WRITE = we; Rdst = dst; RY = ry; Rsrc1 = s1; Rsrc2 = s2;
    p_reset = rst; p_we = we; p_dst = dst; p_ry = ry;
    e.busy = (m_left > 0);
    e.ra_b = exp_read(1'b1, s1);
    e.rb_b = exp_read(1'b1, s2);
    e.ra_n = exp_read(1'b0, s1);
    e.rb_n = exp_read(1'b0, s2);
    sb_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs are combinational, so one response per cycle,
  // sampled at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("busy_byp",  {31'b0, busy_b}, {31'b0, e.busy});
        chk("busy_nbyp", {31'b0, busy_n}, {31'b0, e.busy});
        chk("RA_byp",    ra_b, e.ra_b);
        chk("RB_byp",    rb_b, e.rb_b);
        chk("RA_nbyp",   ra_n, e.ra_n);
        chk("RB_nbyp",   rb_n, e.rb_n);
      end
    end
  end

  task automatic idle_reads(input int n);
    for (int i = 0; i < n; i++)
      step(0, 0, '0, '0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
  endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH; i++)
      step(0, 0, '0, '0, 5'(i), 5'(DEPTH - 1 - i));
  endtask

  task automatic random_phase(input int n);
    bit          we;
    logic [4:0]  d, a, b;
    for (int i = 0; i < n; i++) begin
      we = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 1) == 1) begin
        d = 5'($urandom_range(0, 7)); a = 5'($urandom_range(0, 7)); b = 5'($urandom_range(0, 7));
      end else begin
        d = 5'($urandom); a = 5'($urandom); b = 5'($urandom);
      end
      step(0, we, d, $urandom, a, b);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    reset = 1'b1; RF_WRITE = 1'b0; Rdst = '0; RY = '0; Rsrc1 = '0; Rsrc2 = '0;

    // Clear after a two-cycle reset, then every register reads 0.
    step(1, 0, '0, '0, 5'd1, 5'd2);
    step(1, 0, '0, '0, 5'd3, 5'd4);
    idle_reads(34);
    read_all();

    // Plain write/read: bypassing instance forwards, the other lags a cycle.
    step(0, 1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5);
    step(0, 0, '0, '0, 5'd5, 5'd5);

    // Both ports bypass the same register in one cycle.
    step(0, 1, 5'd7, 32'h12345678, 5'd7, 5'd7);
    step(0, 0, '0, '0, 5'd7, 5'd7);

    // R0 stays zero with and without the bypass condition.
    step(0, 1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    step(0, 0, '0, '0, 5'd0, 5'd7);

    random_phase(300);

    // Mid-clear reset: written register must read 0 after the restart.
    step(0, 1, 5'd9, 32'h99990009, 5'd9, 5'd9);
    step(1, 0, '0, '0, 5'd9, 5'd9);
    idle_reads(9);
    step(1, 0, '0, '0, 5'd9, 5'd3);

    // Writes while busy are dropped and reads stay 0.
    for (int i = 0; i < 34; i++)
      step(0, 1, 5'd3, 32'hA5A5A5A5, 5'd3, 5'd3);
    step(0, 0, '0, '0, 5'd3, 5'd3);
    read_all();

    random_phase(150);

    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_mis++;
      $display("FAIL drain: %0d responses left, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
